// File: rtl/star_pkg.sv
// Shared types and helpers for the star collectible bank: default layout,
// scan FSM states, the box-overlap test and width helpers.
package star_pkg;

   localparam int unsigned OVL_W = 17;

   localparam logic [39:0] STAR_X_DEFAULT = {10'd512, 10'd416, 10'd320, 10'd224};
   localparam logic [39:0] STAR_Y_DEFAULT = {10'd150, 10'd150, 10'd180, 10'd180};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DONE
   } scan_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned cnt_w(input int unsigned frames);
      return (frames == 0) ? 1 : $clog2(frames + 1);
   endfunction

   // Operands are zero-extended coordinates, so the sums below cannot wrap.
   function automatic logic overlap(input logic [OVL_W-1:0] cx, input logic [OVL_W-1:0] cy,
                                    input logic [OVL_W-1:0] sx, input logic [OVL_W-1:0] sy,
                                    input logic [OVL_W-1:0] csz, input logic [OVL_W-1:0] ssz);
      return (cx + csz >= sx) && (cx <= sx + ssz) &&
             (cy + csz >= sy) && (cy <= sy + ssz);
   endfunction

endpackage

// File: rtl/star_slot.sv
// One star's presence flag plus its respawn countdown; a collection reloads
// the countdown, and frame ticks count it down to re-enable the star.
module star_slot
   import star_pkg::*;
#(
   parameter int unsigned RESPAWN_FRAMES = 0
) (
   input  logic sys_clk,
   input  logic RST_N,
   input  logic hit_i,
   input  logic frame_tick_i,
   input  logic clear_i,
   output logic en_o
);

   localparam int unsigned CW = cnt_w(RESPAWN_FRAMES);

   logic          en_q, en_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      en_d  = en_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         en_d  = 1'b1;
         cnt_d = '0;
      end else if (hit_i && en_q) begin
         en_d  = 1'b0;
         cnt_d = CW'(RESPAWN_FRAMES);
      end else if (frame_tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            en_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         en_q  <= 1'b1;
         cnt_q <= '0;
      end else begin
         en_q  <= en_d;
         cnt_q <= cnt_d;
      end
   end

   assign en_o = en_q;

endmodule

// File: rtl/star_bank.sv
// Collectible star manager: per-frame scan of all stars through one shared
// overlap comparator, collection pulses, saturating score and screen mapping.
module star_bank
   import star_pkg::*;
#(
   parameter int unsigned NUM_STARS      = 4,
   parameter int unsigned W              = 10,
   parameter int unsigned CHAR_SIZE      = 12,
   parameter int unsigned STAR_SIZE      = 12,
   parameter int unsigned SCREEN_W       = 640,
   parameter int unsigned RESPAWN_FRAMES = 0,
   parameter int unsigned SCORE_W        = 8,
   parameter logic [NUM_STARS*W-1:0] STAR_X_INIT = STAR_X_DEFAULT,
   parameter logic [NUM_STARS*W-1:0] STAR_Y_INIT = STAR_Y_DEFAULT
) (
   input  logic                          sys_clk,
   input  logic                          RST_N,
   input  logic [W-1:0]                  char_x,
   input  logic [W-1:0]                  char_y,
   input  logic [W-1:0]                  bg_pos,
   input  logic                          frame_tick,
   input  logic                          clear,
   output logic [NUM_STARS*W-1:0]        star_x_scr,
   output logic [NUM_STARS*W-1:0]        star_y,
   output logic [NUM_STARS-1:0]          en_mask,
   output logic [NUM_STARS-1:0]          star_visible,
   output logic                          collect_pulse,
   output logic [idx_w(NUM_STARS)-1:0]   collect_idx,
   output logic [SCORE_W-1:0]            score,
   output logic                          scan_busy,
   output logic                          scan_done,
   output logic                          all_collected
);

   localparam int unsigned IW = idx_w(NUM_STARS);

   scan_state_e          state_q;
   logic [IW-1:0]        idx_q;
   logic [W-1:0]         cx_q, cy_q;
   logic                 pulse_q;
   logic [IW-1:0]        cidx_q;
   logic [SCORE_W-1:0]   score_q;
   logic                 busy_q, done_q;

   logic [NUM_STARS-1:0] en_w;
   logic [NUM_STARS-1:0] hit_vec;
   logic [W-1:0]         sel_x, sel_y;
   logic                 sel_en, hit_now;

   // Shared comparator: mux the star under test by the scan index.
   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_en  = 1'b0;
      hit_vec = '0;
      for (int unsigned i = 0; i < NUM_STARS; i++) begin
         if (idx_q == IW'(i)) begin
            sel_x  = STAR_X_INIT[i*W +: W];
            sel_y  = STAR_Y_INIT[i*W +: W];
            sel_en = en_w[i];
         end
      end
      hit_now = (state_q == ST_SCAN) && sel_en &&
                overlap(OVL_W'(cx_q), OVL_W'(cy_q), OVL_W'(sel_x), OVL_W'(sel_y),
                        OVL_W'(CHAR_SIZE), OVL_W'(STAR_SIZE));
      for (int unsigned i = 0; i < NUM_STARS; i++) begin
         hit_vec[i] = hit_now && (idx_q == IW'(i));
      end
   end

   always_ff @(posedge sys_clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cx_q    <= '0;
         cy_q    <= '0;
         pulse_q <= 1'b0;
         cidx_q  <= '0;
         score_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         pulse_q <= 1'b0;
         score_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         done_q  <= 1'b0;
         if (hit_now) begin
            pulse_q <= 1'b1;
            cidx_q  <= idx_q;
            if (score_q != '1) begin
               score_q <= score_q + 1'b1;
            end
         end
         unique case (state_q)
            ST_IDLE: begin
               if (frame_tick) begin
                  cx_q    <= char_x;
                  cy_q    <= char_y;
                  idx_q   <= '0;
                  state_q <= ST_SCAN;
                  busy_q  <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (idx_q == IW'(NUM_STARS - 1)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_STARS; g++) begin : g_star
      logic [W-1:0] wx, sdx;

      star_slot #(
         .RESPAWN_FRAMES(RESPAWN_FRAMES)
      ) u_slot (
         .sys_clk      (sys_clk),
         .RST_N        (RST_N),
         .hit_i        (hit_vec[g]),
         .frame_tick_i (frame_tick),
         .clear_i      (clear),
         .en_o         (en_w[g])
      );

      assign wx                   = STAR_X_INIT[g*W +: W];
      assign sdx                  = wx - bg_pos;
      assign star_x_scr[g*W +: W] = sdx;
      assign star_y[g*W +: W]     = STAR_Y_INIT[g*W +: W];
      assign star_visible[g]      = en_w[g] && (wx >= bg_pos) && (32'(sdx) < 32'(SCREEN_W));
   end

   assign en_mask       = en_w;
   assign all_collected = (en_w == '0);
   assign collect_pulse = pulse_q;
   assign collect_idx   = cidx_q;
   assign score         = score_q;
   assign scan_busy     = busy_q;
   assign scan_done     = done_q;

endmodule

// File: tb/tb_star_bank.sv
// Bench for star_bank: two instances (default, and respawn=3 with a 2-bit
// score) checked against a frame-level reference model of the star rules.
module tb_star_bank;

   logic        sys_clk = 1'b0;
   logic        RST_N   = 1'b0;
   logic [9:0]  char_x  = '0;
   logic [9:0]  char_y  = '0;
   logic [9:0]  bg_pos  = '0;
   logic        frame_tick = 1'b0;
   logic        clear   = 1'b0;

   logic [39:0] sxs_a, sy_a, sxs_b, sy_b;
   logic [3:0]  vis_a, vis_b;
   logic [3:0]  en_w   [2];
   logic        pulse_w[2];
   logic [1:0]  cidx_w [2];
   logic [7:0]  score_w[2];
   logic        busy_w [2];
   logic        done_w [2];
   logic        allc_w [2];
   logic [7:0]  score_a;
   logic [1:0]  score_b;

   always #5 sys_clk = ~sys_clk;

   star_bank dut_a (
      .sys_clk(sys_clk), .RST_N(RST_N), .char_x(char_x), .char_y(char_y),
      .bg_pos(bg_pos), .frame_tick(frame_tick), .clear(clear),
      .star_x_scr(sxs_a), .star_y(sy_a), .en_mask(en_w[0]), .star_visible(vis_a),
      .collect_pulse(pulse_w[0]), .collect_idx(cidx_w[0]), .score(score_a),
      .scan_busy(busy_w[0]), .scan_done(done_w[0]), .all_collected(allc_w[0])
   );

   star_bank #(.RESPAWN_FRAMES(3), .SCORE_W(2)) dut_b (
      .sys_clk(sys_clk), .RST_N(RST_N), .char_x(char_x), .char_y(char_y),
      .bg_pos(bg_pos), .frame_tick(frame_tick), .clear(clear),
      .star_x_scr(sxs_b), .star_y(sy_b), .en_mask(en_w[1]), .star_visible(vis_b),
      .collect_pulse(pulse_w[1]), .collect_idx(cidx_w[1]), .score(score_b),
      .scan_busy(busy_w[1]), .scan_done(done_w[1]), .all_collected(allc_w[1])
   );

   assign score_w[0] = score_a;
   assign score_w[1] = {6'b0, score_b};

   // Reference model state, per instance.
   int sx_m[4] = '{224, 320, 416, 512};
   int sy_m[4] = '{180, 180, 150, 150};
   int resp[2] = '{0, 3};
   int smax[2] = '{255, 3};
   bit m_en [2][4];
   int m_cnt[2][4];
   int m_score[2];
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            m_en[d][i]  = 1'b1;
            m_cnt[d][i] = 0;
         end
         m_score[d] = 0;
      end
   endtask

   function automatic bit ovl(input int cx, input int cy, input int sx, input int sy);
      return (cx + 12 >= sx) && (cx <= sx + 12) && (cy + 12 >= sy) && (cy <= sy + 12);
   endfunction

   task automatic check_static();
      logic [3:0] exp_en;
      int bg;
      bg = int'(bg_pos);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) exp_en[i] = m_en[d][i];
         chk("en_mask", en_w[d], exp_en);
         chk("score", score_w[d], m_score[d]);
         chk("all_collected", allc_w[d], exp_en == 4'b0);
      end
      for (int i = 0; i < 4; i++) begin
         chk("star_x_scr", sxs_a[i*10 +: 10], (sx_m[i] - bg + 1024) % 1024);
         chk("star_y", sy_a[i*10 +: 10], sy_m[i]);
         chk("star_visible", vis_a[i], m_en[0][i] && (sx_m[i] >= bg) && (sx_m[i] - bg < 640));
      end
   endtask

   task automatic run_frame(input int cx, input int cy);
      bit exp_hit[2][4];
      char_x     = 10'(cx);
      char_y     = 10'(cy);
      frame_tick = 1'b1;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 4; i++) begin
            if (m_cnt[d][i] > 0) begin
               m_cnt[d][i]--;
               if (m_cnt[d][i] == 0) m_en[d][i] = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            exp_hit[d][i] = 1'b0;
            if (m_en[d][i] && ovl(cx, cy, sx_m[i], sy_m[i])) begin
               exp_hit[d][i] = 1'b1;
               m_en[d][i]    = 1'b0;
               m_cnt[d][i]   = resp[d];
               if (m_score[d] < smax[d]) m_score[d]++;
            end
         end
      end
      cyc();
      frame_tick = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("busy_start", busy_w[d], 1'b1);
         chk("pulse_first", pulse_w[d], 1'b0);
      end
      for (int m = 1; m <= 4; m++) begin
         cyc();
         for (int d = 0; d < 2; d++) begin
            chk("pulse", pulse_w[d], exp_hit[d][m-1]);
            if (exp_hit[d][m-1]) chk("collect_idx", cidx_w[d], m - 1);
            chk("scan_done", done_w[d], m == 4);
            chk("busy_scan", busy_w[d], 1'b1);
         end
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
         chk("busy_end", busy_w[d], 1'b0);
         chk("done_end", done_w[d], 1'b0);
         chk("pulse_end", pulse_w[d], 1'b0);
      end
      check_static();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      model_reset();
   endtask

   initial begin
      int cx, cy, j;
      int bnd_x[6]   = '{212, 211, 236, 237, 224, 224};
      int bnd_y[6]   = '{180, 180, 180, 180, 168, 167};
      bit bnd_hit[6] = '{1, 0, 1, 0, 1, 0};

      // Reset state, bg_pos = 0.
      model_reset();
      repeat (3) cyc();
      for (int d = 0; d < 2; d++) begin
         chk("rst_pulse", pulse_w[d], 1'b0);
         chk("rst_idx", cidx_w[d], 2'd0);
         chk("rst_busy", busy_w[d], 1'b0);
         chk("rst_done", done_w[d], 1'b0);
      end
      chk("rst_en", en_w[0], 4'b1111);
      chk("rst_scr0", sxs_a[9:0], 10'd224);
      chk("rst_vis", vis_a, 4'b1111);
      check_static();
      RST_N = 1'b1;
      cyc();

      // First collection, then a repeat tick with no further effect.
      run_frame(220, 176);
      chk("first_score", score_a, 8'd1);
      chk("first_en", en_w[0], 4'b1110);
      run_frame(220, 176);
      chk("repeat_score", score_a, 8'd1);

      // Inclusive edges on star 0.
      for (int k = 0; k < 6; k++) begin
         do_clear();
         run_frame(bnd_x[k], bnd_y[k]);
         chk("boundary", en_w[0][0], !bnd_hit[k]);
      end

      // Repeated respawn + collection of star 1 saturates the 2-bit score.
      do_clear();
      for (int k = 0; k < 12; k++) run_frame(316, 176);
      chk("score_sat", score_b, 2'd3);

      // Respawn timing with a frame_tick injected mid-scan.
      do_clear();
      run_frame(316, 176);
      chk("resp_taken", en_w[1][1], 1'b0);
      char_x = '0;
      char_y = '0;
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("resp_midscan_en", en_w[1][1], 1'b0);
      cyc();
      cyc();
      chk("resp_done", done_w[1], 1'b1);
      cyc();
      chk("resp_no_restart", busy_w[1], 1'b0);
      chk("resp_before", en_w[1][1], 1'b0);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      chk("resp_back", en_w[1][1], 1'b1);
      repeat (6) cyc();
      m_cnt[1][1] = 0;
      m_en[1][1]  = 1'b1;
      check_static();

      // clear mid-scan with an overlapping character, plus a coincident tick.
      do_clear();
      char_x = 10'd220;
      char_y = 10'd176;
      frame_tick = 1'b1;
      cyc();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      frame_tick = 1'b0;
      model_reset();
      for (int k = 0; k < 6; k++) begin
         for (int d = 0; d < 2; d++) begin
            chk("clr_pulse", pulse_w[d], 1'b0);
            chk("clr_done", done_w[d], 1'b0);
            chk("clr_busy", busy_w[d], 1'b0);
         end
         cyc();
      end
      check_static();

      // Scroll offset mapping.
      bg_pos = 10'd300;
      #1;
      chk("bg_scr0", sxs_a[9:0], 10'd948);
      chk("bg_vis0", vis_a[0], 1'b0);
      chk("bg_scr1", sxs_a[19:10], 10'd20);
      chk("bg_vis1", vis_a[1], 1'b1);

      // Randomised frames near the stars, random scroll offsets.
      for (int k = 0; k < 40; k++) begin
         bg_pos = 10'($urandom_range(0, 1023));
         j = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            cx = int'($urandom_range(0, 1023));
            cy = int'($urandom_range(0, 1023));
         end else begin
            cx = sx_m[j] - 16 + int'($urandom_range(0, 32));
            cy = sy_m[j] - 16 + int'($urandom_range(0, 32));
         end
         run_frame(cx, cy);
         if (k == 25) do_clear();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/star_bank.md
Name: star_bank

Overview:
- Parametrised collectible manager for NUM_STARS stars at fixed world positions.
- Once per frame it scans the stars one per cycle through a single shared overlap comparator. It tests each star against the character bounding box.
- On a hit it disables the star, emits a collect pulse with the star index, and increments a saturating score.
- Optional per-star respawn timers. It sits between the character-motion logic and the renderer/scoreboard.

Parameters:
- NUM_STARS, 4, number of stars (1..16).
- W, 10, coordinate width.
- CHAR_SIZE, 12, character box edge in pixels.
- STAR_SIZE, 12, star box edge in pixels.
- SCREEN_W, 640, visible width used for star_visible.
- RESPAWN_FRAMES, 0, frames until a collected star reappears; 0 means never.
- SCORE_W, 8, score width.
- STAR_X_INIT, {512,416,320,224}, packed NUM_STARS*W world X (star 0 in LSBs).
- STAR_Y_INIT, {150,150,180,180}, packed NUM_STARS*W world Y.

Ports:
- sys_clk  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- char_x  in  W  character world X (top-left)
- char_y  in  W  character world Y (top-left)
- bg_pos  in  W  scroll offset
- frame_tick  in  1  one-cycle start-of-frame strobe
- clear  in  1  synchronous level restart
- star_x_scr  out  NUM_STARS*W  per-star screen X = world X - bg_pos, mod 2^W
- star_y  out  NUM_STARS*W  per-star Y (constant)
- en_mask  out  NUM_STARS  star present
- star_visible  out  NUM_STARS  en & (X >= bg_pos) & (X - bg_pos < SCREEN_W)
- collect_pulse  out  1  one-cycle collection event
- collect_idx  out  $clog2(NUM_STARS) (min 1)  index of collected star
- score  out  SCORE_W  stars collected, saturating
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle end-of-scan strobe
- all_collected  out  1  en_mask == 0

Behaviour:
- Reset values:
  - en_mask all 1s, score 0.
  - collect_pulse, collect_idx, scan_busy, scan_done all 0.
  - Respawn counters 0; FSM in IDLE.
- FSM states IDLE, SCAN, DONE:
  - IDLE: frame_tick at cycle T latches char_x/char_y and sets idx=0. SCAN is active from T+1.
  - SCAN: idx=i tests star i. idx==NUM_STARS-1 goes to DONE, else idx+1.
  - DONE: scan_done=1 for one cycle (T+1+NUM_STARS), then IDLE.
  - scan_busy=1 in SCAN and DONE.
  - frame_tick while not in IDLE does not start or restart a scan. It still clocks the respawn timers.
- Overlap test uses W+1-bit unsigned arithmetic with no wrap. Hit when all of these hold:
  - cx+CHAR_SIZE >= sx
  - cx <= sx+STAR_SIZE
  - cy+CHAR_SIZE >= sy
  - cy <= sy+STAR_SIZE
- Edges are inclusive.
- Hit on an enabled star i (registered at the edge ending that SCAN cycle):
  - en_mask[i] <= 0.
  - collect_pulse=1 and collect_idx=i during cycle T+2+i.
  - score += 1, holding at all-ones.
  - Respawn counter i <= RESPAWN_FRAMES.
- Hit on a disabled star: no effect.
- Multiple hits in one scan produce pulses in consecutive cycles.
- collect_idx holds its last value when the pulse is 0.
- Respawn:
  - Every frame_tick decrements each nonzero counter.
  - A 1->0 transition sets en_mask[i]=1.
  - A collection load in the same cycle takes priority over the decrement.
  - RESPAWN_FRAMES=0 never re-enables a star.
- clear has top priority:
  - FSM to IDLE, aborting any scan with no pulse and no scan_done.
  - en_mask all 1s, score 0, counters 0, collect_pulse 0.
  - A frame_tick in the same cycle as clear is ignored.
- Reset mid-scan behaves the same as clear, asynchronously.
- star_x_scr, star_y, star_visible and all_collected are combinational from registers, parameters and bg_pos.

Decomposition:
- Package star_pkg holds:
  - the default position vectors
  - the FSM state enum
  - an overlap function (W+1-bit compare)
  - an index-width helper
- Sub-module star_slot, instantiated NUM_STARS times, owns:
  - the enable flag and respawn counter
  - inputs: hit, frame_tick, clear
  - output: en
- Top level owns the FSM, latch, shared comparator, score and screen-coordinate math.

Test Plan:
- Reset with bg_pos=0 -> en_mask=4'b1111, score=0, star_x_scr[0]=224, star_visible=4'b1111, no pulse.
- Char (220,176), frame_tick at T -> collect_pulse at T+2, collect_idx=0, score=1, en_mask=4'b1110, scan_done at T+5. Repeat the tick -> no pulse, score stays 1.
- Boundaries on star0 with char_y=180:
  - char_x=212 hits; 211 misses.
  - char_x=236 hits; 237 misses.
  - char_y=168 hits; 167 misses.
- SCORE_W=2 with repeated hits and respawns -> score saturates at 3.
- RESPAWN_FRAMES=3: collect star1 -> en_mask[1] returns to 1 the cycle after the 3rd subsequent frame_tick. frame_tick pulsed during the scan is ignored for scanning.
- clear asserted at T+2 mid-scan with char overlapping star0 -> no collect_pulse, no scan_done, en_mask=4'b1111, score=0.
- bg_pos=300 -> star_x_scr[0]=948, star_visible[0]=0, star_x_scr[1]=20, star_visible[1]=1.
